// File: rtl/move_history_stack_pkg.sv
// Shared definitions for the move history stack: record layout, piece,
// castling and en-passant codes, and the control FSM state encoding.
// Imported by move_history_stack and sq_onehot_codec.
package move_history_stack_pkg;

  // Record geometry
  localparam int RECORD_W = 32;
  localparam int SQ_W     = 6;
  localparam int PIECE_W  = 6;
  localparam int CAST_W   = 2;
  localparam int EP_W     = 5;

  // Bit offsets of each field inside a 32-bit record (LSB first)
  localparam int OFF_FROM     = 0;
  localparam int OFF_TO       = 6;
  localparam int OFF_MOVING   = 12;
  localparam int OFF_CAPTURED = 18;
  localparam int OFF_CASTLING = 24;
  localparam int OFF_EP       = 26;
  localparam int OFF_COLOR    = 31;

  // One-hot piece codes, pawn in bit0 up to king in bit5
  localparam logic [PIECE_W-1:0] PIECE_NONE   = 6'b000000;
  localparam logic [PIECE_W-1:0] PIECE_PAWN   = 6'b000001;
  localparam logic [PIECE_W-1:0] PIECE_ROOK   = 6'b000010;
  localparam logic [PIECE_W-1:0] PIECE_KNIGHT = 6'b000100;
  localparam logic [PIECE_W-1:0] PIECE_BISHOP = 6'b001000;
  localparam logic [PIECE_W-1:0] PIECE_QUEEN  = 6'b010000;
  localparam logic [PIECE_W-1:0] PIECE_KING   = 6'b100000;

  // Castling codes
  localparam logic [CAST_W-1:0] CASTLE_NONE  = 2'b00;
  localparam logic [CAST_W-1:0] CASTLE_QUEEN = 2'b01;
  localparam logic [CAST_W-1:0] CASTLE_KING  = 2'b10;

  // En-passant codes
  localparam logic [EP_W-1:0] EP_NONE = 5'b00001;
  localparam logic [EP_W-1:0] EP_UL   = 5'b00010;
  localparam logic [EP_W-1:0] EP_UR   = 5'b00100;
  localparam logic [EP_W-1:0] EP_DL   = 5'b01000;
  localparam logic [EP_W-1:0] EP_DR   = 5'b10000;

  // Packed record; field order from MSB matches the OFF_* offsets above
  typedef struct packed {
    logic               color;
    logic [EP_W-1:0]    enpassant;
    logic [CAST_W-1:0]  castling;
    logic [PIECE_W-1:0] captured;
    logic [PIECE_W-1:0] moving;
    logic [SQ_W-1:0]    to_sq;
    logic [SQ_W-1:0]    from_sq;
  } record_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP_RD = 2'd1,
    ST_ISSUE  = 2'd2
  } state_e;

  // True when exactly one bit of a piece code is set
  function automatic logic is_onehot6(input logic [PIECE_W-1:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/move_history_stack_sq_onehot_codec.sv
// Square codec: 64-bit one-hot -> 6-bit index with validity flag, and
// 6-bit index -> 64-bit one-hot. Purely combinational, no backpressure.
// Ports: onehot_i/idx_o/is_onehot_o (encoder), idx_i/onehot_o (decoder).
module sq_onehot_codec
  import move_history_stack_pkg::*;
(
  input  logic [63:0]     onehot_i,
  output logic [SQ_W-1:0] idx_o,
  output logic            is_onehot_o,
  input  logic [SQ_W-1:0] idx_i,
  output logic [63:0]     onehot_o
);

  // OR of the indices of all set bits; equals the index when one-hot.
  // Garbage for malformed inputs, which is_onehot_o flags.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 64; i++) begin
      if (onehot_i[i]) idx_o = idx_o | SQ_W'(i);
    end
  end

  // Non-zero with no second bit: clearing the lowest set bit leaves zero
  assign is_onehot_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 64'd1)) == '0);

  assign onehot_o = 64'd1 << idx_i;

endmodule

// File: rtl/move_history_stack.sv
// LIFO of committed chess moves; an undo pops the newest record and replays
// it to the board updater with undo=1. Latency: undo accepted at edge N ->
// out_valid from edge N+2, held until upd_ack. Backpressure: push_ready low
// while full, while undo_req is high, and whenever a pop is in flight.
// Ports: push_* (move in, valid/ready), undo_req, upd_ack, record outputs
// (initialPosition..color_type, undo, out_valid), count/empty/full, err_sticky.
module move_history_stack
  import move_history_stack_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [63:0]   push_initialPosition,
  input  logic [63:0]   push_movedPosition,
  input  logic [5:0]    push_movingPiece,
  input  logic [5:0]    push_capturedPiece,
  input  logic [1:0]    push_castling,
  input  logic [4:0]    push_enpassant,
  input  logic          push_color,
  input  logic          undo_req,
  input  logic          upd_ack,
  output logic [63:0]   initialPosition,
  output logic [63:0]   movedPosition,
  output logic [5:0]    movingPiece,
  output logic [5:0]    capturedPiece,
  output logic [1:0]    castling,
  output logic [4:0]    enpassant,
  output logic          color_type,
  output logic          undo,
  output logic          out_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          err_sticky
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          out_valid_q;
  logic          undo_q;
  logic [AW-1:0] rd_addr_q;
  record_t       rd_rec_q;
  record_t       push_rec;
  record_t       mem_q [DEPTH];

  logic [63:0]   init_pos_q, moved_pos_q;
  logic [5:0]    moving_q, captured_q;
  logic [1:0]    castling_q;
  logic [4:0]    ep_q;
  logic          color_q;

  // Codec outputs for the from- and to-square
  logic [SQ_W-1:0] from_idx, to_idx;
  logic            from_ok, to_ok;
  logic [63:0]     from_dec, to_dec;

  logic is_idle, empty_w, full_w, wellformed;
  logic push_fire, push_ok, undo_fire;

  sq_onehot_codec u_from_codec (
    .onehot_i    (push_initialPosition),
    .idx_o       (from_idx),
    .is_onehot_o (from_ok),
    .idx_i       (rd_rec_q.from_sq),
    .onehot_o    (from_dec)
  );

  sq_onehot_codec u_to_codec (
    .onehot_i    (push_movedPosition),
    .idx_o       (to_idx),
    .is_onehot_o (to_ok),
    .idx_i       (rd_rec_q.to_sq),
    .onehot_o    (to_dec)
  );

  assign is_idle    = (state_q == ST_IDLE);
  assign empty_w    = (count_q == '0);
  assign full_w     = (count_q == DEPTH_C);
  assign wellformed = from_ok && to_ok && is_onehot6(push_movingPiece);

  // Undo has priority over a simultaneous push
  assign push_ready = is_idle && !full_w && !undo_req;
  assign push_fire  = push_valid && push_ready;
  assign push_ok    = push_fire && wellformed;
  assign undo_fire  = is_idle && undo_req && !empty_w;

  always_comb begin
    push_rec           = '0;
    push_rec.from_sq   = from_idx;
    push_rec.to_sq     = to_idx;
    push_rec.moving    = push_movingPiece;
    push_rec.captured  = push_capturedPiece;
    push_rec.castling  = push_castling;
    push_rec.enpassant = push_enpassant;
    push_rec.color     = push_color;
  end

  always_comb begin
    count_d = count_q;
    if (push_ok)        count_d = count_q + (AW+1)'(1);
    else if (undo_fire) count_d = count_q - (AW+1)'(1);
  end

  // Errors: underflow, a malformed push, or a push offered while full.
  // A push that loses to a same-cycle undo is not an error.
  always_comb begin
    err_d = err_q;
    if (is_idle) begin
      if (undo_req && empty_w)                                  err_d = 1'b1;
      if (!undo_req && push_valid && (full_w || !wellformed))   err_d = 1'b1;
    end
  end

  // Storage: one write port, one registered read port. The read runs every
  // cycle; the pop address is stable from POP_RD onward, so rd_rec_q holds
  // the popped record by the first ISSUE cycle.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[count_q[AW-1:0]] <= push_rec;
    rd_rec_q <= mem_q[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      undo_q      <= 1'b0;
      rd_addr_q   <= '0;
      init_pos_q  <= '0;
      moved_pos_q <= '0;
      moving_q    <= '0;
      captured_q  <= '0;
      castling_q  <= '0;
      ep_q        <= '0;
      color_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (undo_fire) begin
            // Newest record sits at count-1; AW-bit wrap covers count==DEPTH
            rd_addr_q <= count_q[AW-1:0] - AW'(1);
            state_q   <= ST_POP_RD;
          end
        end
        ST_POP_RD: begin
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!out_valid_q) begin
            // First ISSUE cycle: latch the decoded record
            init_pos_q  <= from_dec;
            moved_pos_q <= to_dec;
            moving_q    <= rd_rec_q.moving;
            captured_q  <= rd_rec_q.captured;
            castling_q  <= rd_rec_q.castling;
            ep_q        <= rd_rec_q.enpassant;
            color_q     <= rd_rec_q.color;
            out_valid_q <= 1'b1;
            undo_q      <= 1'b1;
          end else if (upd_ack) begin
            out_valid_q <= 1'b0;
            undo_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign initialPosition = init_pos_q;
  assign movedPosition   = moved_pos_q;
  assign movingPiece     = moving_q;
  assign capturedPiece   = captured_q;
  assign castling        = castling_q;
  assign enpassant       = ep_q;
  assign color_type      = color_q;
  assign undo            = undo_q;
  assign out_valid       = out_valid_q;
  assign count           = count_q;
  assign empty           = empty_w;
  assign full            = full_w;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_move_history_stack.sv
// Bench for move_history_stack: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the stack.
module tb_move_history_stack;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        push_valid, push_ready;
  logic [63:0] push_initialPosition, push_movedPosition;
  logic [5:0]  push_movingPiece, push_capturedPiece;
  logic [1:0]  push_castling;
  logic [4:0]  push_enpassant;
  logic        push_color;
  logic        undo_req, upd_ack;
  logic [63:0] initialPosition, movedPosition;
  logic [5:0]  movingPiece, capturedPiece;
  logic [1:0]  castling;
  logic [4:0]  enpassant;
  logic        color_type, undo, out_valid;
  logic [6:0]  count;
  logic        empty, full, err_sticky;

  always #5 clk = ~clk;

  move_history_stack #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .clear_n(clear_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_initialPosition(push_initialPosition), .push_movedPosition(push_movedPosition),
    .push_movingPiece(push_movingPiece), .push_capturedPiece(push_capturedPiece),
    .push_castling(push_castling), .push_enpassant(push_enpassant), .push_color(push_color),
    .undo_req(undo_req), .upd_ack(upd_ack),
    .initialPosition(initialPosition), .movedPosition(movedPosition),
    .movingPiece(movingPiece), .capturedPiece(capturedPiece),
    .castling(castling), .enpassant(enpassant), .color_type(color_type),
    .undo(undo), .out_valid(out_valid), .count(count),
    .empty(empty), .full(full), .err_sticky(err_sticky)
  );

  typedef struct {
    int         from_idx;
    int         to_idx;
    logic [5:0] moving;
    logic [5:0] captured;
    logic [1:0] cast;
    logic [4:0] ep;
    logic       color;
  } mv_t;

  // Reference model: a plain queue plus pop-in-flight bookkeeping
  mv_t stk[$];
  int  m_delay   = 0;     // cycles until a popped record appears
  bit  m_ov      = 0;     // record currently issued
  bit  m_err     = 0;
  bit  model_live = 0;
  mv_t m_rec;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string tag, input mv_t e);
    chk({tag, "_from"},  initialPosition, 64'd1 << e.from_idx);
    chk({tag, "_to"},    movedPosition,   64'd1 << e.to_idx);
    chk({tag, "_mov"},   64'(movingPiece),   64'(e.moving));
    chk({tag, "_cap"},   64'(capturedPiece), 64'(e.captured));
    chk({tag, "_cast"},  64'(castling),      64'(e.cast));
    chk({tag, "_ep"},    64'(enpassant),     64'(e.ep));
    chk({tag, "_color"}, 64'(color_type),    64'(e.color));
  endtask

  function automatic int idx_of(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Outputs implied by the model state and the inputs of the current cycle
  task automatic compare();
    bit busy;
    busy = m_ov || (m_delay > 0);
    chk("count",      64'(count),      64'(stk.size()));
    chk("empty",      64'(empty),      64'(stk.size() == 0));
    chk("full",       64'(full),       64'(stk.size() == 64));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    chk("out_valid",  64'(out_valid),  64'(m_ov));
    chk("undo",       64'(undo),       64'(m_ov));
    chk("push_ready", 64'(push_ready), 64'(!busy && stk.size() < 64 && !undo_req));
    if (m_ov) chk_rec("issued", m_rec);
  endtask

  task automatic model_step();
    mv_t n;
    if (!clear_n) begin
      stk.delete();
      m_delay = 0; m_ov = 0; m_err = 0;
    end else if (m_delay > 0) begin
      m_delay--;
      if (m_delay == 0) m_ov = 1;
    end else if (m_ov) begin
      if (upd_ack) m_ov = 0;
    end else if (undo_req) begin
      if (stk.size() == 0) m_err = 1;
      else begin
        m_rec   = stk.pop_back();
        m_delay = 2;
      end
    end else if (push_valid) begin
      if (stk.size() == 64) m_err = 1;
      else if ($countones(push_initialPosition) != 1 || $countones(push_movedPosition) != 1 ||
               $countones(push_movingPiece) != 1) m_err = 1;
      else begin
        n.from_idx = idx_of(push_initialPosition);
        n.to_idx   = idx_of(push_movedPosition);
        n.moving   = push_movingPiece;
        n.captured = push_capturedPiece;
        n.cast     = push_castling;
        n.ep       = push_enpassant;
        n.color    = push_color;
        stk.push_back(n);
      end
    end
  endtask

  // Called at a negedge with the cycle's inputs already driven
  task automatic tick();
    #1;
    if (model_live) compare();
    @(posedge clk);
    model_step();
    model_live = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear_n = 1'b1; push_valid = 1'b0; undo_req = 1'b0; upd_ack = 1'b0;
  endtask

  task automatic drive_move(input mv_t m);
    push_valid           = 1'b1;
    push_initialPosition = 64'd1 << m.from_idx;
    push_movedPosition   = 64'd1 << m.to_idx;
    push_movingPiece     = m.moving;
    push_capturedPiece   = m.captured;
    push_castling        = m.cast;
    push_enpassant       = m.ep;
    push_color           = m.color;
  endtask

  function automatic mv_t rand_move();
    mv_t m;
    m.from_idx = $urandom_range(0, 63);
    m.to_idx   = $urandom_range(0, 63);
    m.moving   = 6'd1 << $urandom_range(0, 5);
    m.captured = ($urandom_range(0, 2) == 0) ? 6'd0 : (6'd1 << $urandom_range(0, 5));
    m.cast     = 2'($urandom_range(0, 2));
    m.ep       = 5'd1 << $urandom_range(0, 4);
    m.color    = 1'($urandom_range(0, 1));
    return m;
  endfunction

  task automatic do_reset();
    idle_inputs(); clear_n = 1'b0; tick(); clear_n = 1'b1;
  endtask

  task automatic do_push(input mv_t m);
    drive_move(m); tick(); push_valid = 1'b0;
  endtask

  // Undo, wait (bounded) for the issued record, check it, then acknowledge
  task automatic do_undo_expect(input mv_t e, input string tag);
    int w;
    undo_req = 1'b1; tick(); undo_req = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 8) begin tick(); w++; end
    chk({tag, "_ov"}, 64'(out_valid), 64'd1);
    chk_rec(tag, e);
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mv_t p, a, b, c, m;
    mv_t moves[64];
    logic [63:0] sq49, sq56;
    int w;

    idle_inputs();
    clear_n = 1'b0;
    push_initialPosition = '0; push_movedPosition = '0;
    push_movingPiece = '0; push_capturedPiece = '0;
    push_castling = '0; push_enpassant = '0; push_color = 1'b0;
    @(negedge clk);
    tick();                       // first reset edge, nothing compared yet
    clear_n = 1'b1;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_err",   64'(err_sticky), 64'd0);
    chk("rst_ov",    64'(out_valid), 64'd0);
    chk("rst_undo",  64'(undo), 64'd0);
    chk("rst_from",  initialPosition, 64'd0);
    chk("rst_ready", 64'(push_ready), 64'd1);

    // 1: pawn 49->56 captures rook, then undo
    p.from_idx = 49; p.to_idx = 56; p.moving = 6'b000001; p.captured = 6'b000010;
    p.cast = 2'b00; p.ep = 5'b00001; p.color = 1'b1;
    sq49 = 64'd1 << 49; sq56 = 64'd1 << 56;
    do_push(p);
    chk("s1_count1", 64'(count), 64'd1);
    undo_req = 1'b1; tick(); undo_req = 1'b0;
    chk("s1_count0", 64'(count), 64'd0);
    chk("s1_ov_n",   64'(out_valid), 64'd0);
    tick();
    chk("s1_ov_n1",  64'(out_valid), 64'd0);
    tick();
    chk("s1_ov_n2",  64'(out_valid), 64'd1);
    chk("s1_undo",   64'(undo), 64'd1);
    chk("s1_from",   initialPosition, sq49);
    chk("s1_to",     movedPosition, sq56);
    chk("s1_mov",    64'(movingPiece), 64'h01);
    chk("s1_cap",    64'(capturedPiece), 64'h02);
    tick();
    chk("s1_hold_ov",   64'(out_valid), 64'd1);
    chk("s1_hold_from", initialPosition, sq49);
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    chk("s1_ack_ov",   64'(out_valid), 64'd0);
    chk("s1_ack_undo", 64'(undo), 64'd0);

    // 2: A, B, C then three undos -> C, B, A
    do_reset();
    a = rand_move(); b = rand_move(); c = rand_move();
    do_push(a); do_push(b); do_push(c);
    chk("s2_count3", 64'(count), 64'd3);
    do_undo_expect(c, "s2_C");
    do_undo_expect(b, "s2_B");
    do_undo_expect(a, "s2_A");
    chk("s2_empty", 64'(empty), 64'd1);
    chk("s2_err",   64'(err_sticky), 64'd0);

    // 3: fill to 64, then a 65th push
    do_reset();
    for (int i = 0; i < 64; i++) begin
      moves[i] = rand_move();
      do_push(moves[i]);
    end
    chk("s3_full",  64'(full), 64'd1);
    chk("s3_count", 64'(count), 64'd64);
    chk("s3_err0",  64'(err_sticky), 64'd0);
    drive_move(rand_move());
    #1 chk("s3_ready65", 64'(push_ready), 64'd0);
    tick(); push_valid = 1'b0;
    chk("s3_count65", 64'(count), 64'd64);
    chk("s3_err1",    64'(err_sticky), 64'd1);
    do_undo_expect(moves[63], "s3_last");
    chk("s3_count63", 64'(count), 64'd63);

    // 4: undo on empty
    do_reset();
    undo_req = 1'b1; tick(); undo_req = 1'b0;
    tick(); tick();
    chk("s4_ov",    64'(out_valid), 64'd0);
    chk("s4_err",   64'(err_sticky), 64'd1);
    chk("s4_ready", 64'(push_ready), 64'd1);

    // 5: malformed push together with undo while count=2
    do_reset();
    a = rand_move(); b = rand_move();
    do_push(a); do_push(b);
    drive_move(rand_move());
    push_initialPosition = 64'h3;
    undo_req = 1'b1;
    #1 chk("s5_ready", 64'(push_ready), 64'd0);
    tick(); undo_req = 1'b0;
    chk("s5_count", 64'(count), 64'd1);
    tick();
    tick();
    chk("s5_issue_ready", 64'(push_ready), 64'd0);
    chk("s5_issue_ov",    64'(out_valid), 64'd1);
    chk_rec("s5_rec", b);
    push_valid = 1'b0;
    upd_ack = 1'b1; tick(); upd_ack = 1'b0;
    chk("s5_err", 64'(err_sticky), 64'd0);

    // 6: reset during ISSUE without ack
    do_reset();
    do_push(rand_move());
    undo_req = 1'b1; tick(); undo_req = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 8) begin tick(); w++; end
    chk("s6_ov_before", 64'(out_valid), 64'd1);
    clear_n = 1'b0; tick(); clear_n = 1'b1;
    chk("s6_ov",    64'(out_valid), 64'd0);
    chk("s6_undo",  64'(undo), 64'd0);
    chk("s6_count", 64'(count), 64'd0);
    chk("s6_ready", 64'(push_ready), 64'd1);

    // Random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle_inputs();
      if ($urandom_range(0, 299) == 0) clear_n = 1'b0;
      if ($urandom_range(0, 6) == 0) undo_req = 1'b1;
      if ($urandom_range(0, 1) == 0) upd_ack = 1'b1;
      if ($urandom_range(0, 9) < 6) begin
        m = rand_move();
        drive_move(m);
        if ($urandom_range(0, 11) == 0) begin
          case ($urandom_range(0, 3))
            0: push_initialPosition = 64'd0;
            1: push_movedPosition   = push_movedPosition | (64'd1 << ((m.to_idx + 1) % 64));
            2: push_movingPiece     = 6'b000011;
            default: push_movingPiece = 6'b000000;
          endcase
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
